nl_stream_driver: RTL and testbench
===================================

NL_STREAM_DRIVER -- requirements
Module: nl_stream_driver

Interface
REQ-001 SHALL have parameter LANES, default 32: int8 lanes per beat; beat width is 8*LANES.
REQ-002 SHALL have parameter ADDR_W, default 10: width of the SRAM word address.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports start (input, 1) and busy, done (output, 1): job control; done is a one-cycle pulse.
REQ-006 SHALL have ports src_base, dst_base (input, ADDR_W) and beat_count (input, 16): job descriptor.
REQ-007 SHALL have ports in_scale_cfg, out_scale_cfg (input, 32) and nl_in_scale, nl_out_scale (output, 32): scale pass-through to the nonlinear unit.
REQ-008 SHALL have SRAM read ports rd_en (output, 1), rd_addr (output, ADDR_W) and rd_data (input, 8*LANES); read latency is 1 cycle.
REQ-009 SHALL have SRAM write ports wr_en (output, 1), wr_addr (output, ADDR_W) and wr_data (output, 8*LANES).
REQ-010 SHALL have unit-request ports nl_in_valid (output, 1), nl_in_ready (input, 1) and nl_in_data (output, 8*LANES): initiator side of the unit's data_in handshake.
REQ-011 SHALL have unit-response ports nl_out_valid (input, 1), nl_out_ready (output, 1) and nl_out_data (input, 8*LANES): consumer side of the unit's data_out handshake.

Function
REQ-012 SHALL implement the FSM IDLE -> FETCH -> LOAD -> SEND -> COLLECT -> STORE -> (FETCH | FIN) -> IDLE.
REQ-013 SHALL, in IDLE with start=1, latch src_base, dst_base, beat_count, in_scale_cfg and out_scale_cfg, then go to FETCH, or to FIN if beat_count=0.
REQ-014 SHALL ignore start whenever the FSM is not in IDLE; busy SHALL be 1 in every state except IDLE.
REQ-015 SHALL assert rd_en for exactly the FETCH cycle, with rd_addr = src_base + beat index.
REQ-016 SHALL, in LOAD, register rd_data into the nl_in_data holding register.
REQ-017 SHALL hold nl_in_valid=1 throughout SEND, with nl_in_data stable, and leave SEND in the cycle after nl_in_valid and nl_in_ready are both 1.
REQ-018 SHALL hold nl_out_ready=1 throughout COLLECT and capture nl_out_data in the cycle nl_out_valid=1, then go to STORE.
REQ-019 SHALL drop nl_out_valid if it arrives outside COLLECT; nl_out_ready SHALL be 0 outside COLLECT.
REQ-020 SHALL assert wr_en for exactly the STORE cycle, with wr_addr = dst_base + beat index and wr_data = the captured result; the beat index then increments.
REQ-021 SHALL go from STORE to FETCH while the incremented index is less than the latched count, and to FIN otherwise.
REQ-022 SHALL pulse done for the single FIN cycle and then return to IDLE.
REQ-023 SHALL drive nl_in_scale and nl_out_scale from the latched values, holding them constant from start until the next accepted start.
REQ-024 SHALL compute address sums modulo 2^ADDR_W (wrap-around, no error).
REQ-025 SHALL give a minimum per-beat latency of 5 cycles (FETCH to STORE) with zero-wait handshakes; waits extend SEND and COLLECT only.

Reset
REQ-026 SHALL, on rst=0, immediately force the FSM to IDLE and clear the beat index and all latched values.
REQ-027 SHALL reset every output to 0, including mid-job; the in-flight beat is abandoned and never written.

Configuration
REQ-028 SHALL, with NL_STREAM_PERF_EN defined, add output perf_cycles (32): cleared on an accepted start, incremented every non-IDLE cycle, saturating at 2^32-1, held after FIN, and reset to 0.
REQ-029 SHALL, without NL_STREAM_PERF_EN, have neither the perf_cycles port nor the counter logic.

Structure
REQ-030 SHALL place the FSM state enum and the LANES and lane-width constants in the shared package nl_pkg.
REQ-031 SHALL be a single module with no sub-modules; the handshake registers stay inline.

Verification
REQ-032 SHALL cover: src_base=0, dst_base=0x100, beat_count=3, unit always ready with response 1 cycle later -> 3 writes to 0x100..0x102, done 16 cycles after start.
REQ-033 SHALL cover: beat_count=0 -> done pulses 1 cycle after start, with no rd_en, wr_en or nl_in_valid ever.
REQ-034 SHALL cover: nl_in_ready held 0 for 7 cycles -> nl_in_valid stays 1 and nl_in_data unchanged throughout, with exactly one transfer.
REQ-035 SHALL cover: src_base=0x3FE, beat_count=4 -> reads at 0x3FE, 0x3FF, 0x000, 0x001.
REQ-036 SHALL cover: rst asserted while in COLLECT -> all outputs 0 immediately, no wr_en; a new start then runs a clean job.
REQ-037 SHALL cover, with NL_STREAM_PERF_EN: a second start while busy is ignored, and perf_cycles equals the measured start-to-FIN span.

Source files
------------

// File: rtl/nl_pkg.sv
// nl_pkg: shared constants and FSM state type
// for the nonlinear-unit stream driver.
package nl_pkg;

  localparam int NL_LANES  = 32;
  localparam int NL_LANE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_COLLECT,
    S_STORE,
    S_FIN
  } nl_state_e;

endpackage

// File: rtl/nl_stream_driver.sv
// nl_stream_driver: SRAM -> nonlinear unit -> SRAM beat mover.
// Optional NL_STREAM_PERF_EN adds a job cycle counter (perf_cycles).
module nl_stream_driver
  import nl_pkg::*;
#(
  parameter int LANES  = NL_LANES,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [ADDR_W-1:0]        src_base,
  input  logic [ADDR_W-1:0]        dst_base,
  input  logic [15:0]              beat_count,
  input  logic [31:0]              in_scale_cfg,
  input  logic [31:0]              out_scale_cfg,
  output logic [31:0]              nl_in_scale,
  output logic [31:0]              nl_out_scale,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [NL_LANE_W*LANES-1:0] rd_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [NL_LANE_W*LANES-1:0] wr_data,
  output logic                     nl_in_valid,
  input  logic                     nl_in_ready,
  output logic [NL_LANE_W*LANES-1:0] nl_in_data,
  input  logic                     nl_out_valid,
  output logic                     nl_out_ready,
  input  logic [NL_LANE_W*LANES-1:0] nl_out_data
`ifdef NL_STREAM_PERF_EN
  ,
  output logic [31:0]              perf_cycles
`endif
);

  localparam int DW = NL_LANE_W * LANES;

  nl_state_e         r_state;
  nl_state_e         w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [15:0]       r_cnt;
  logic [15:0]       r_idx;
  logic [31:0]       r_isc;
  logic [31:0]       r_osc;
  logic [DW-1:0]     r_in_data;
  logic [DW-1:0]     r_out_data;
  logic [15:0]       w_idx_inc;
  logic              w_accept;
  logic [ADDR_W-1:0] w_rd_sum;
  logic [ADDR_W-1:0] w_wr_sum;

  assign w_idx_inc = r_idx + 16'd1;
  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_rd_sum  = r_src + r_idx[ADDR_W-1:0];
  assign w_wr_sum  = r_dst + r_idx[ADDR_W-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; handshakes only stretch SEND and COLLECT.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (start)
          w_next = (beat_count == 16'd0) ? S_FIN : S_FETCH;
      S_FETCH:   w_next = S_LOAD;
      S_LOAD:    w_next = S_SEND;
      S_SEND:
        if (nl_in_ready) w_next = S_COLLECT;
      S_COLLECT:
        if (nl_out_valid) w_next = S_STORE;
      S_STORE:
        w_next = (w_idx_inc < r_cnt) ? S_FETCH : S_FIN;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Job descriptor latch, beat index and data holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_isc      <= '0;
      r_osc      <= '0;
      r_in_data  <= '0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_src <= src_base;
        r_dst <= dst_base;
        r_cnt <= beat_count;
        r_isc <= in_scale_cfg;
        r_osc <= out_scale_cfg;
        r_idx <= '0;
      end
      if (r_state == S_LOAD)
        r_in_data <= rd_data;
      if (r_state == S_COLLECT && nl_out_valid)
        r_out_data <= nl_out_data;
      if (r_state == S_STORE)
        r_idx <= w_idx_inc;
    end
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_FIN);
  assign rd_en        = (r_state == S_FETCH);
  assign rd_addr      = rd_en ? w_rd_sum : '0;
  assign wr_en        = (r_state == S_STORE);
  assign wr_addr      = wr_en ? w_wr_sum : '0;
  assign wr_data      = wr_en ? r_out_data : '0;
  assign nl_in_valid  = (r_state == S_SEND);
  assign nl_in_data   = r_in_data;
  assign nl_out_ready = (r_state == S_COLLECT);
  assign nl_in_scale  = r_isc;
  assign nl_out_scale = r_osc;

`ifdef NL_STREAM_PERF_EN
  logic [31:0] r_perf;

  // Saturating count of non-idle cycles for the current job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) r_perf <= '0;
    end else if (r_perf != '1) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_nl_stream_driver.sv
// tb_nl_stream_driver: scoreboard bench with SRAM and
// nonlinear-unit models for nl_stream_driver.
module tb_nl_stream_driver;

  localparam int LANES = 32;
  localparam int AW    = 10;
  localparam int DW    = 8 * LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] src_base = '0, dst_base = '0;
  logic [15:0]   beat_count = '0;
  logic [31:0]   in_scale_cfg = '0, out_scale_cfg = '0;
  logic [31:0]   nl_in_scale, nl_out_scale;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data = '0, wr_data;
  logic          nl_in_valid, nl_out_ready;
  logic          nl_in_ready = 1'b1, nl_out_valid = 1'b0;
  logic [DW-1:0] nl_in_data, nl_out_data = '0;
`ifdef NL_STREAM_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  nl_stream_driver #(.LANES(LANES), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .src_base(src_base), .dst_base(dst_base),
    .beat_count(beat_count),
    .in_scale_cfg(in_scale_cfg),
    .out_scale_cfg(out_scale_cfg),
    .nl_in_scale(nl_in_scale),
    .nl_out_scale(nl_out_scale),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .nl_in_valid(nl_in_valid), .nl_in_ready(nl_in_ready),
    .nl_in_data(nl_in_data),
    .nl_out_valid(nl_out_valid), .nl_out_ready(nl_out_ready),
    .nl_out_data(nl_out_data)
`ifdef NL_STREAM_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [DW-1:0] mem [1024];
  logic [AW-1:0] rd_q [$];
  wr_t           wr_q [$];

  int checks = 0;
  int errors = 0;
  int stall_left = 0;
  int out_dly = 0;
  int n_rd = 0, n_wr = 0, n_val = 0, n_xfer = 0;

  // The nonlinear unit's function: per 32-bit word, xor then add.
  function automatic logic [DW-1:0] f(input logic [DW-1:0] x,
                                      input logic [31:0] s,
                                      input logic [31:0] o);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < DW / 32; k++)
      r[32*k +: 32] = (x[32*k +: 32] ^ s) + o;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkd(input string nm, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM (1-cycle read latency) and nonlinear unit model.
  initial begin
    logic          p_rd, p_in_hs, p_out_hs, pend;
    logic [AW-1:0] p_ra;
    logic [DW-1:0] p_in_d, od;
    int            wcnt;
    p_rd = 0; p_in_hs = 0; p_out_hs = 0; pend = 0;
    p_ra = '0; p_in_d = '0; od = '0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        p_rd = 0; p_in_hs = 0; p_out_hs = 0; pend = 0;
        wcnt = 0;
        nl_out_valid = 0;
        nl_in_ready = 1;
      end else begin
        if (p_rd) rd_data = mem[p_ra];
        else      rd_data = {8{$urandom}};
        if (wr_en) mem[wr_addr] = wr_data;
        p_rd = rd_en;
        p_ra = rd_addr;
        if (p_out_hs) pend = 0;
        else if (pend && wcnt > 0) wcnt--;
        if (p_in_hs) begin
          pend = 1;
          wcnt = out_dly;
          od = f(p_in_d, nl_in_scale, nl_out_scale);
        end
        nl_out_valid = pend && (wcnt == 0);
        nl_out_data  = pend ? od : {8{$urandom}};
        if (nl_in_valid && stall_left > 0) begin
          nl_in_ready = 0;
          stall_left--;
        end else begin
          nl_in_ready = 1;
        end
        p_in_hs  = nl_in_valid && nl_in_ready;
        p_in_d   = nl_in_data;
        p_out_hs = nl_out_valid && nl_out_ready;
      end
    end
  end

  // Monitor: pops expected reads/writes as the DUT presents them.
  initial begin
    logic          hold_v;
    logic [DW-1:0] hold_d;
    wr_t           e;
    hold_v = 0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rd_en) begin
        n_rd++;
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got addr %0h expected none",
                   rd_addr);
        end else begin
          chk("rd_addr", 64'(rd_addr), 64'(rd_q.pop_front()));
        end
      end
      if (wr_en) begin
        n_wr++;
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got addr %0h expected none",
                   wr_addr);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e.a));
          chkd("wr_data", wr_data, e.d);
        end
      end
      if (nl_in_valid) begin
        n_val++;
        if (hold_v) chkd("in_data_stable", nl_in_data, hold_d);
        if (nl_in_ready) n_xfer++;
        hold_v = !nl_in_ready;
        hold_d = nl_in_data;
      end else begin
        hold_v = 0;
      end
    end
  end

  task automatic run_job(input logic [AW-1:0] src,
                         input logic [AW-1:0] dst,
                         input int cnt,
                         input logic [31:0] isc,
                         input logic [31:0] osc,
                         input int stall,
                         input int dly,
                         input bit dup);
    int            exp_lat, n, lim;
    logic [AW-1:0] a;
    wr_t           e;
    for (int b = 0; b < cnt; b++) begin
      a = src + AW'(b);
      rd_q.push_back(a);
      e.a = dst + AW'(b);
      e.d = f(mem[a], isc, osc);
      wr_q.push_back(e);
    end
    exp_lat = (cnt == 0) ? 1 : 1 + cnt * (5 + dly) + stall;
    lim = exp_lat + 40;
    @(negedge clk);
    stall_left = stall;
    out_dly = dly;
    n_rd = 0; n_wr = 0; n_val = 0; n_xfer = 0;
    start = 1;
    src_base = src;
    dst_base = dst;
    beat_count = 16'(cnt);
    in_scale_cfg = isc;
    out_scale_cfg = osc;
    #1;
    chk("busy_at_start", 64'(busy), 64'd0);
    @(negedge clk);
    start = 0;
    src_base = AW'($urandom);
    dst_base = AW'($urandom);
    beat_count = 16'($urandom);
    in_scale_cfg = $urandom;
    out_scale_cfg = $urandom;
    n = 1;
    #1;
    while (!done && n < lim) begin
      @(negedge clk);
      #1;
      n++;
      start = dup && (n == 3);
    end
    start = 0;
    chk("done_latency", 64'(n), 64'(exp_lat));
    chk("busy_in_fin", 64'(busy), 64'd1);
    chk("nl_in_scale", 64'(nl_in_scale), 64'(isc));
    chk("nl_out_scale", 64'(nl_out_scale), 64'(osc));
    @(negedge clk);
    #3;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_fin", 64'(busy), 64'd0);
`ifdef NL_STREAM_PERF_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(n));
`endif
    chk("rd_count", 64'(n_rd), 64'(cnt));
    chk("wr_count", 64'(n_wr), 64'(cnt));
    chk("xfer_count", 64'(n_xfer), 64'(cnt));
    chk("valid_cycles", 64'(n_val), 64'(cnt + stall));
    chk("queues_empty", 64'(rd_q.size() + wr_q.size()), 64'd0);
  endtask

  task automatic reset_in_collect();
    int n;
    wr_t e;
    rd_q.push_back(10'h020);
    e.a = 10'h220;
    e.d = f(mem[10'h020], 32'h1, 32'h2);
    wr_q.push_back(e);
    @(negedge clk);
    out_dly = 4;
    stall_left = 0;
    start = 1;
    src_base = 10'h020;
    dst_base = 10'h220;
    beat_count = 16'd2;
    in_scale_cfg = 32'h1;
    out_scale_cfg = 32'h2;
    @(negedge clk);
    start = 0;
    n = 0;
    #1;
    while (!nl_out_ready && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reached_collect", 64'(nl_out_ready), 64'd1);
    rst = 0;
    rd_q.delete();
    wr_q.delete();
    #1;
    chk("rst_outputs_zero",
        64'(|{busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
              nl_in_valid, nl_in_data, nl_out_ready,
              nl_in_scale, nl_out_scale}), 64'd0);
`ifdef NL_STREAM_PERF_EN
    chk("rst_perf_zero", 64'(perf_cycles), 64'd0);
`endif
    repeat (2) @(negedge clk);
    #1;
    rst = 1;
    out_dly = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] s;
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < DW / 32; k++)
        mem[i][32*k +: 32] = $urandom;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs_zero",
        64'(|{busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
              nl_in_valid, nl_in_data, nl_out_ready,
              nl_in_scale, nl_out_scale}), 64'd0);
    rst = 1;
    repeat (2) @(negedge clk);

    run_job(10'h000, 10'h100, 3, 32'h0000_00A5, 32'h0000_0003,
            0, 0, 0);
    run_job(10'h040, 10'h140, 0, 32'h1234_5678, 32'h9ABC_DEF0,
            0, 0, 0);
    run_job(10'h050, 10'h250, 1, 32'h0F0F_0F0F, 32'h1, 7, 0, 0);
    run_job(10'h3FE, 10'h100, 4, 32'hDEAD_BEEF, 32'h10, 0, 0, 0);
    run_job(10'h060, 10'h260, 3, 32'h5555_AAAA, 32'h7, 1, 1, 1);
    reset_in_collect();
    run_job(10'h070, 10'h270, 2, 32'hCAFE_F00D, 32'h42, 0, 0, 0);
    for (int j = 0; j < 6; j++) begin
      s = AW'($urandom);
      run_job(s, s + AW'(512), int'($urandom_range(1, 6)),
              $urandom, $urandom,
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), j[0]);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
